ows_frame_parser: RTL

OWS_FRAME_PARSER -- requirements
Module: ows_frame_parser

---
 rtl/ows_frame_parser.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ows_frame_parser.sv
// One-wire slave frame parser: ROM/function command decode, address assembly
// and a small FWFT write buffer carrying (address, data) pairs.
module ows_frame_parser #(
  parameter int DATA_W     = 8,
  parameter int UID_BYTES  = 8,
  parameter int ADDR_BYTES = 2,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        start_flg,
  input  logic                        stop_flag,
  input  logic [UID_BYTES*DATA_W-1:0] dev_uid,
  output logic [DATA_W-1:0]           rom_cmd,
  output logic [DATA_W-1:0]           fun_cmd,
  output logic [UID_BYTES*DATA_W-1:0] uid_rx,
  output logic [ADDR_BYTES*DATA_W-1:0] address,
  output logic                        selected,
  output logic                        err,
  output logic                        ovf,
  output logic                        hdr_done,
  output logic                        byte_ack,
  output logic [DATA_W-1:0]           wr_data,
  output logic [ADDR_BYTES*DATA_W-1:0] wr_addr,
  output logic                        wr_valid,
  input  logic                        wr_ready
);

  localparam int UW = UID_BYTES * DATA_W;
  localparam int AW = ADDR_BYTES * DATA_W;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(UID_BYTES + ADDR_BYTES + 1);
  localparam logic [DATA_W-1:0] MATCH_ROM = DATA_W'(8'h55);
  localparam logic [DATA_W-1:0] SKIP_ROM  = DATA_W'(8'hCC);

  typedef enum logic [2:0] {
    IDLE, ROM, UID, FUN, ADDR, DATA, IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   nidx;
  logic [UW-1:0]   uid_nx;
  logic            uid_last, addr_last;
  logic            acc, push;

  logic [DATA_W-1:0] dmem [WBUF_DEPTH];
  logic [AW-1:0]     amem [WBUF_DEPTH];
  logic [PW:0]       wp, rp;
  logic              full, empty, pop, do_push;

  assign uid_last  = (cnt == CW'(UID_BYTES - 1));
  assign addr_last = (cnt == CW'(ADDR_BYTES - 1));
  // a byte only counts if neither stop nor restart claims the cycle
  assign acc  = din_valid && !stop_flag && !start_flg &&
                (state_q inside {ROM, UID, FUN, ADDR, DATA});
  assign push = acc && (state_q == DATA);

  always_comb begin
    uid_nx = uid_rx;
    for (int k = 0; k < UID_BYTES; k++)
      if (cnt == CW'(k)) uid_nx[k*DATA_W +: DATA_W] = din;
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      stop_flag: state_d = IDLE;
      start_flg: state_d = ROM;
      acc: begin
        case (state_q)
          ROM: begin
            if (din == MATCH_ROM)     state_d = UID;
            else if (din == SKIP_ROM) state_d = FUN;
            else                      state_d = IGNORE;
          end
          UID: if (uid_last)
            state_d = (uid_nx == dev_uid) ? FUN : IGNORE;
          FUN:  state_d = ADDR;
          ADDR: if (addr_last) state_d = DATA;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cmd  <= '0;
      fun_cmd  <= '0;
      uid_rx   <= '0;
      address  <= '0;
      selected <= 1'b0;
      err      <= 1'b0;
      hdr_done <= 1'b0;
      byte_ack <= 1'b0;
      cnt      <= '0;
      nidx     <= '0;
    end else begin
      byte_ack <= acc;
      hdr_done <= acc && (state_q == ADDR) && addr_last;
      if (!stop_flag && start_flg) begin
        rom_cmd  <= '0;
        fun_cmd  <= '0;
        uid_rx   <= '0;
        address  <= '0;
        selected <= 1'b0;
        err      <= 1'b0;
        cnt      <= '0;
        nidx     <= '0;
      end else if (acc) begin
        case (state_q)
          ROM: begin
            rom_cmd <= din;
            if (din == SKIP_ROM)       selected <= 1'b1;
            else if (din != MATCH_ROM) err      <= 1'b1;
          end
          UID: begin
            uid_rx <= uid_nx;
            cnt    <= uid_last ? '0 : cnt + 1'b1;
            if (uid_last && (uid_nx == dev_uid)) selected <= 1'b1;
          end
          FUN: fun_cmd <= din;
          ADDR: begin
            for (int k = 0; k < ADDR_BYTES; k++)
              if (cnt == CW'(k)) address[k*DATA_W +: DATA_W] <= din;
            cnt <= addr_last ? '0 : cnt + 1'b1;
          end
          DATA: nidx <= nidx + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign empty    = (wp == rp);
  assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign pop      = !empty && wr_ready;
  // when full, a same-cycle pop frees the slot the push lands in
  assign do_push  = push && (!full || pop);
  assign wr_valid = !empty;
  assign wr_data  = dmem[rp[PW-1:0]];
  assign wr_addr  = amem[rp[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      for (int k = 0; k < WBUF_DEPTH; k++) begin
        dmem[k] <= '0;
        amem[k] <= '0;
      end
    end else begin
      if (pop) rp <= rp + 1'b1;
      if (do_push) begin
        dmem[wp[PW-1:0]] <= din;
        amem[wp[PW-1:0]] <= address + nidx;
        wp <= wp + 1'b1;
      end
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

endmodule
